// File: rtl/bus_tx_pkg.sv
// Shared definitions for the round-robin serial bus transmitter:
// FSM state type, default CRC polynomial and frame geometry helpers.
package bus_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_GAP
    } tx_state_t;

    // x^4 + x + 1 with the x^4 term implicit
    localparam int unsigned DEFAULT_POLY = 32'h3;

    function automatic int unsigned frame_len(input int unsigned addr_w,
                                              input int unsigned data_w,
                                              input int unsigned crc_w);
        return 1 + addr_w + data_w + crc_w;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_bits);
        return (max_bits <= 1) ? 1 : $clog2(max_bits);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set pending bit strictly after ptr,
// wrapping modulo N_CH, returned both one-hot and as a binary index.
module rr_arbiter
    import bus_tx_pkg::*;
#(
    parameter int unsigned N_CH = 16
) (
    input  logic [N_CH-1:0]         pending,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [N_CH-1:0]         onehot,
    output logic [$clog2(N_CH)-1:0] idx,
    output logic                    any
);

    localparam int unsigned IDX_W = $clog2(N_CH);

    always_comb begin
        int unsigned cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Offset N_CH lands back on ptr itself, so the last owner is considered last.
        for (int unsigned off = 1; off <= N_CH; off++) begin
            cand = (32'(ptr) + off) % N_CH;
            if (!any && pending[IDX_W'(cand)]) begin
                any                  = 1'b1;
                onehot[IDX_W'(cand)] = 1'b1;
                idx                  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/rr_serial_bus_tx.sv
// Shared serial bus transmitter: N_CH channels post frames that are serialised
// as start bit, address, payload and a CRC computed on the fly.
module rr_serial_bus_tx
    import bus_tx_pkg::*;
#(
    parameter int unsigned      N_CH   = 16,
    parameter int unsigned      DATA_W = 64,
    parameter int unsigned      ADDR_W = 4,
    parameter int unsigned      CRC_W  = 4,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(DEFAULT_POLY)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    input  logic [N_CH*ADDR_W-1:0]   addr_in,
    input  logic [N_CH*CRC_W-1:0]    crc_in,
    output logic                     bus_show,
    output logic                     bus_valid,
    output logic                     busy,
    output logic [N_CH-1:0]          grant,
    output logic [$clog2(N_CH)-1:0]  grant_id,
    output logic                     done,
    output logic                     crc_err
);

    localparam int unsigned IDX_W = $clog2(N_CH);
    localparam int unsigned CNT_W = cnt_width(max3(ADDR_W, DATA_W, CRC_W));

    tx_state_t          state;
    tx_state_t          state_nx;
    logic [N_CH-1:0]    pending;
    logic [N_CH-1:0]    clr;
    logic [IDX_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]  addr_sh;
    logic [DATA_W-1:0]  data_sh;
    logic [CRC_W-1:0]   crc_exp;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_nx;
    logic [CRC_W-1:0]   crc_sh;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;
    logic               cur_bit;
    logic [N_CH-1:0]    arb_onehot;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .pending (pending),
        .ptr     (rr_ptr),
        .onehot  (arb_onehot),
        .idx     (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        bus_show  = 1'b0;
        bus_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        crc_err   = 1'b0;
        cur_bit   = 1'b0;
        clr       = '0;
        cnt_zero  = (cnt == '0);
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nx = ST_START;
                    clr      = arb_onehot;
                end
            end
            ST_START: begin
                bus_show  = 1'b1;
                bus_valid = 1'b1;
                busy      = 1'b1;
                state_nx  = ST_ADDR;
            end
            ST_ADDR: begin
                cur_bit   = addr_sh[ADDR_W-1];
                bus_show  = cur_bit;
                bus_valid = 1'b1;
                busy      = 1'b1;
                if (cnt_zero) begin
                    state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                cur_bit   = data_sh[DATA_W-1];
                bus_show  = cur_bit;
                bus_valid = 1'b1;
                busy      = 1'b1;
                if (cnt_zero) begin
                    state_nx = ST_CRC;
                end
            end
            ST_CRC: begin
                bus_show  = crc_sh[CRC_W-1];
                bus_valid = 1'b1;
                busy      = 1'b1;
                if (cnt_zero) begin
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                done     = 1'b1;
                crc_err  = (crc_q != crc_exp);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // MSB-first serial CRC, init 0, fed only by address and payload bits
        crc_nx = (crc_q << 1) ^ ((crc_q[CRC_W-1] ^ cur_bit) ? POLY : '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            rr_ptr   <= IDX_W'(N_CH - 1);
            grant    <= '0;
            grant_id <= '0;
            addr_sh  <= '0;
            data_sh  <= '0;
            crc_exp  <= '0;
            crc_q    <= '0;
            crc_sh   <= '0;
            cnt      <= '0;
        end else begin
            pending <= (pending | req) & ~clr;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        addr_sh  <= addr_in[ADDR_W * 32'(arb_idx) +: ADDR_W];
                        data_sh  <= data_in[DATA_W * 32'(arb_idx) +: DATA_W];
                        crc_exp  <= crc_in[CRC_W * 32'(arb_idx) +: CRC_W];
                        crc_q    <= '0;
                        rr_ptr   <= arb_idx;
                        grant    <= arb_onehot;
                        grant_id <= arb_idx;
                    end
                end
                ST_START: begin
                    cnt <= CNT_W'(ADDR_W - 1);
                end
                ST_ADDR: begin
                    crc_q   <= crc_nx;
                    addr_sh <= addr_sh << 1;
                    cnt     <= cnt_zero ? CNT_W'(DATA_W - 1) : cnt - CNT_W'(1);
                end
                ST_DATA: begin
                    crc_q   <= crc_nx;
                    data_sh <= data_sh << 1;
                    if (cnt_zero) begin
                        cnt    <= CNT_W'(CRC_W - 1);
                        crc_sh <= crc_nx;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CRC: begin
                    crc_sh <= crc_sh << 1;
                    if (cnt_zero) begin
                        grant    <= '0;
                        grant_id <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_serial_bus_tx.sv
// Self-checking bench for rr_serial_bus_tx: frame-level reference model with
// per-cycle output comparison, plus directed checks on an 8-bit-payload instance.
module tb_rr_serial_bus_tx;
    import bus_tx_pkg::*;

    localparam int NC = 16;
    localparam int L  = int'(frame_len(4, 64, 4));

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // default-width instance
    logic [NC-1:0]    req;
    logic [NC*64-1:0] data_in;
    logic [NC*4-1:0]  addr_in;
    logic [NC*4-1:0]  crc_in;
    logic             bus_show, bus_valid, busy, done, crc_err;
    logic [NC-1:0]    grant;
    logic [3:0]       grant_id;

    // 8-bit payload instance
    logic [NC-1:0]    req8;
    logic [NC*8-1:0]  data8;
    logic [NC*4-1:0]  addr8;
    logic [NC*4-1:0]  crc8;
    logic             bus_show8, bus_valid8, busy8, done8, crc_err8;
    logic [NC-1:0]    grant8;
    logic [3:0]       grant_id8;

    rr_serial_bus_tx dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .addr_in   (addr_in),
        .crc_in    (crc_in),
        .bus_show  (bus_show),
        .bus_valid (bus_valid),
        .busy      (busy),
        .grant     (grant),
        .grant_id  (grant_id),
        .done      (done),
        .crc_err   (crc_err)
    );

    rr_serial_bus_tx #(
        .DATA_W (8)
    ) dut8 (
        .clock     (clock),
        .reset     (reset),
        .req       (req8),
        .data_in   (data8),
        .addr_in   (addr8),
        .crc_in    (crc8),
        .bus_show  (bus_show8),
        .bus_valid (bus_valid8),
        .busy      (busy8),
        .grant     (grant8),
        .grant_id  (grant_id8),
        .done      (done8),
        .crc_err   (crc_err8)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // CRC as remainder of (message * x^4) mod (x^4 + x + 1), by long division
    function automatic logic [3:0] crc_model(input logic [3:0] a, input logic [63:0] d, input int dw);
        logic [4:0] r;
        bit         msg[$];
        r = '0;
        for (int i = 3; i >= 0; i--) msg.push_back(a[i]);
        for (int i = dw - 1; i >= 0; i--) msg.push_back(d[i]);
        repeat (4) msg.push_back(1'b0);
        foreach (msg[k]) begin
            r = {r[3:0], msg[k]};
            if (r[4]) r = r ^ 5'h13;
        end
        return r[3:0];
    endfunction

    // ---------------- reference model ----------------
    bit          m_inflight = 0;
    int          m_t        = 0;
    int          m_owner    = 0;
    int          m_ptr      = NC - 1;
    logic [15:0] m_pend     = '0;
    logic [72:0] m_frame    = '0;
    bit          m_err      = 0;

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                m_inflight = 0;
                m_pend     = '0;
                m_ptr      = NC - 1;
            end else begin
                int          win;
                logic [3:0]  a;
                logic [63:0] d;
                logic [3:0]  c;
                win = -1;
                if (m_inflight) begin
                    m_t++;
                    if (m_t == L + 2) m_inflight = 0;
                end
                if (!m_inflight) begin
                    for (int k = 1; k <= NC; k++) begin
                        if (m_pend[(m_ptr + k) % NC]) begin
                            win = (m_ptr + k) % NC;
                            break;
                        end
                    end
                end
                for (int i = 0; i < NC; i++) m_pend[i] = (m_pend[i] | req[i]) && (i != win);
                if (win >= 0) begin
                    a          = addr_in[win*4 +: 4];
                    d          = data_in[win*64 +: 64];
                    c          = crc_in[win*4 +: 4];
                    m_frame    = {1'b1, a, d, crc_model(a, d, 64)};
                    m_err      = (crc_model(a, d, 64) != c);
                    m_inflight = 1;
                    m_t        = 0;
                    m_owner    = win;
                    m_ptr      = win;
                end
            end
        end
    end

    function automatic logic [24:0] exp_out();
        if (reset || !m_inflight) return '0;
        if (m_t < L) return {m_frame[72 - m_t], 1'b1, 1'b1, 1'b0, 1'b0, 16'(16'd1 << m_owner), 4'(m_owner)};
        if (m_t == L) return {1'b0, 1'b0, 1'b0, 1'b1, m_err, 16'd0, 4'd0};
        return '0;
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            check($sformatf("outputs@%0d", cyc),
                  128'({bus_show, bus_valid, busy, done, crc_err, grant, grant_id}),
                  128'(exp_out()));
        end
    end

    // ---------------- observation of the default instance ----------------
    int          g_id[$];
    int          g_cyc[$];
    int          done_cnt   = 0;
    logic [72:0] sh         = '0;
    logic [72:0] last_frame = '0;
    logic        busy_q     = 1'b0;

    initial begin
        forever begin
            @(negedge clock);
            if (busy && !busy_q) begin
                g_id.push_back(int'(grant_id));
                g_cyc.push_back(cyc);
            end
            busy_q = busy;
            if (bus_valid) sh = {sh[71:0], bus_show};
            if (done) begin
                done_cnt++;
                last_frame = sh;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!m_inflight && m_pend == '0 && req == '0) begin
                ok = 1;
                break;
            end
            tick();
        end
        check(name, 128'(ok), 128'(1));
    endtask

    task automatic run8(input logic [3:0] c, input bit want_err, input string tag);
        logic [16:0] bits;
        int          valid_n;
        int          bad_gnt;
        int          lat;
        bits    = '0;
        valid_n = 0;
        bad_gnt = 0;
        lat     = 0;
        crc8    = '0;
        crc8[3:0] = c;
        addr8   = '0;
        data8   = '0;
        req8    = 16'h0001;
        tick();
        req8 = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (bus_valid8) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(2));
        for (int k = 0; k < 17; k++) begin
            bits    = {bits[15:0], bus_show8};
            valid_n += int'(bus_valid8);
            if (grant8 !== 16'h0001 || grant_id8 !== 4'd0 || busy8 !== 1'b1) bad_gnt++;
            @(negedge clock);
        end
        check({tag, "_bits"}, 128'(bits), 128'(17'h10000));
        check({tag, "_valid_len"}, 128'(valid_n), 128'(17));
        check({tag, "_grant"}, 128'(bad_gnt), 128'(0));
        check({tag, "_done"}, 128'({done8, bus_valid8, busy8}), 128'(3'b100));
        check({tag, "_crc_err"}, 128'(crc_err8), 128'(want_err));
        tick();
    endtask

    initial begin
        int          n0;
        int          d0;
        bit          seen;
        logic [63:0] x;
        req     = '0;
        data_in = '0;
        addr_in = '0;
        crc_in  = '0;
        req8    = '0;
        data8   = '0;
        addr8   = '0;
        crc8    = '0;

        tick();
        tick();
        check("reset_outputs", 128'({bus_show, bus_valid, busy, done, crc_err, grant, grant_id}), 128'(0));
        check("reset_outputs8", 128'({bus_show8, bus_valid8, busy8, done8, crc_err8, grant8, grant_id8}), 128'(0));
        reset = 1'b0;
        tick();

        check("pin_crc_zero", 128'(crc_model(4'h0, 64'h0, 8)), 128'(4'h0));
        check("pin_crc_d1_w8", 128'(crc_model(4'h0, 64'h1, 8)), 128'(4'h3));
        check("pin_crc_a1_w8", 128'(crc_model(4'h1, 64'h0, 8)), 128'(4'hF));
        check("pin_crc_a1d1_w64", 128'(crc_model(4'h1, 64'h1, 64)), 128'(4'h6));

        run8(4'h0, 1'b0, "w8_crc_ok");
        run8(4'h5, 1'b1, "w8_crc_bad");

        // ch1: addr 1, data 1
        addr_in[1*4 +: 4]   = 4'h1;
        data_in[1*64 +: 64] = 64'h1;
        crc_in[1*4 +: 4]    = 4'h6;
        d0  = done_cnt;
        req = 16'h0002;
        tick();
        req = '0;
        wait_idle("ch1_idle");
        check("ch1_frame", 128'(last_frame), 128'({1'b1, 4'h1, 64'h1, 4'h6}));
        check("ch1_done_once", 128'(done_cnt - d0), 128'(1));

        // ch2: payload changes mid-frame
        x = 64'hDEAD_BEEF_0123_4567;
        data_in[2*64 +: 64] = x;
        addr_in[2*4 +: 4]   = 4'hA;
        req = 16'h0004;
        tick();
        req = '0;
        repeat (20) tick();
        data_in[2*64 +: 64] = ~x;
        addr_in[2*4 +: 4]   = 4'h5;
        wait_idle("ch2_idle");
        check("ch2_latched_data", 128'(last_frame[67:4]), 128'(x));
        check("ch2_latched_addr", 128'(last_frame[71:68]), 128'(4'hA));

        // reset during bit 30 of a ch4 frame
        req = 16'h0010;
        tick();
        req  = '0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus_valid) begin
                seen = 1;
                break;
            end
        end
        check("abort_frame_started", 128'(seen), 128'(1));
        repeat (30) @(negedge clock);
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1;
        check("abort_lines", 128'({bus_show, bus_valid, busy, done, grant}), 128'(0));
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("abort_no_done", 128'(done_cnt - d0), 128'(0));
        n0  = g_id.size();
        req = 16'h0009;
        tick();
        req = '0;
        for (int k = 0; k < 10 && g_id.size() <= n0; k++) tick();
        check("post_reset_first", 128'((g_id.size() > n0) ? g_id[n0] : -1), 128'(0));
        wait_idle("post_reset_idle");

        // all channels requesting continuously
        do_reset();
        n0  = g_id.size();
        req = '1;
        for (int k = 0; k < 17 * (L + 2) + 50 && g_id.size() < n0 + 17; k++) tick();
        req = '0;
        check("rr_frames_seen", 128'(g_id.size() >= n0 + 17), 128'(1));
        for (int k = 0; k < 17; k++) begin
            if (g_id.size() > n0 + k)
                check($sformatf("rr_id%0d", k), 128'(g_id[n0 + k]), 128'(k % 16));
        end
        for (int k = 0; k < 16; k++) begin
            if (g_id.size() > n0 + k + 1)
                check($sformatf("rr_gap%0d", k), 128'(g_cyc[n0 + k + 1] - g_cyc[n0 + k]), 128'(75));
        end
        do_reset();

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            for (int ch = 0; ch < NC; ch++) begin
                if ($urandom_range(0, 3) == 0) begin
                    data_in[ch*64 +: 64] = {$urandom, $urandom};
                    addr_in[ch*4 +: 4]   = 4'($urandom);
                    if ($urandom_range(0, 1) == 1)
                        crc_in[ch*4 +: 4] = crc_model(addr_in[ch*4 +: 4], data_in[ch*64 +: 64], 64);
                    else
                        crc_in[ch*4 +: 4] = 4'($urandom);
                end
            end
            req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            repeat ($urandom_range(1, 25)) tick();
        end
        req = '0;
        wait_idle("random_idle");
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
